// File: rtl/branch_predict_unit_pkg.sv
// Shared RV32I front-end types: machine word, opcode encodings and the
// 2-bit saturating counter step used by the direction predictor.
package rv32i_types;

  typedef logic [31:0] rv32i_word;

  typedef enum logic [6:0] {
    op_br   = 7'b1100011,
    op_jal  = 7'b1101111,
    op_jalr = 7'b1100111
  } rv32i_opcode;

  // Counter value loaded at reset: weakly not-taken.
  localparam logic [1:0] ctr_init = 2'b01;

  // One training step of a 2-bit saturating counter.
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] result;
    if (taken) begin
      if (ctr == 2'b11) begin
        result = ctr;
      end else begin
        result = ctr + 2'b01;
      end
    end else begin
      if (ctr == 2'b00) begin
        result = ctr;
      end else begin
        result = ctr - 2'b01;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/branch_predict_unit_btb.sv
// Direct-mapped branch target buffer. Lookup is combinational; fill is a
// synchronous, unconditional overwrite. Only the valid bits are reset.
module btb_array
  import rv32i_types::*;
#(
  parameter int s_index = 9
) (
  input  logic      clk,
  input  logic      rst,
  input  rv32i_word lookup_pc,
  output logic      hit,
  output rv32i_word target,
  input  logic      fill_en,
  input  rv32i_word fill_pc,
  input  rv32i_word fill_target
);

  localparam int entries = 2 ** s_index;
  localparam int tag_w   = 30 - s_index;

  logic             valid_r  [entries];
  logic [tag_w-1:0] tag_r    [entries];
  rv32i_word        target_r [entries];

  logic [s_index-1:0] lookup_idx_s;
  logic [s_index-1:0] fill_idx_s;
  logic [tag_w-1:0]   lookup_tag_s;
  logic [tag_w-1:0]   fill_tag_s;
  logic               unused_pc_bits_s;

  assign lookup_idx_s = lookup_pc[s_index+1:2];
  assign lookup_tag_s = lookup_pc[31:s_index+2];
  assign fill_idx_s   = fill_pc[s_index+1:2];
  assign fill_tag_s   = fill_pc[31:s_index+2];

  // Instructions are word aligned, so the byte offset never selects anything.
  assign unused_pc_bits_s = ^{lookup_pc[1:0], fill_pc[1:0]};

  // Lookup: the current array contents, so a same-cycle fill is seen next cycle.
  always_comb begin
    hit    = 1'b0;
    target = 32'h0000_0000;
    if (valid_r[lookup_idx_s] && (tag_r[lookup_idx_s] == lookup_tag_s)) begin
      hit    = 1'b1;
      target = target_r[lookup_idx_s];
    end else begin
      hit    = 1'b0;
      target = 32'h0000_0000;
    end
  end

  // Valid bits: cleared by reset, set by any fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < entries; i++) begin
        valid_r[i] <= 1'b0;
      end
    end else if (fill_en) begin
      valid_r[fill_idx_s] <= 1'b1;
    end
  end

  // Tag/target payload: no reset needed because valid gates every use.
  always_ff @(posedge clk) begin
    if (!rst && fill_en) begin
      tag_r[fill_idx_s]    <= fill_tag_s;
      target_r[fill_idx_s] <= fill_target;
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Gshare direction predictor plus BTB. Fetch queries combinationally with
// fetch_pc; execute trains the counters/history on branches and fills the
// BTB on every redirect (branches and jumps alike).
module branch_predict_unit
  import rv32i_types::*;
#(
  parameter int sr_size = 6,
  parameter int s_index = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        fetch_pc,
  output logic               predict_taken,
  output logic [31:0]        predict_target,
  output logic               btb_hit,
  output logic               pht_taken,
  output logic [sr_size-1:0] bhr_out,
  input  logic [6:0]         exec_opcode,
  input  logic [31:0]        exec_pc,
  input  logic               exec_pcmux_sel,
  input  logic [31:0]        exec_alu,
  input  logic [sr_size-1:0] exec_bhr
);

  localparam int pht_entries = 2 ** sr_size;

  logic [1:0]         pht_r [pht_entries];
  logic [sr_size-1:0] bhr_r;

  logic [sr_size-1:0] fidx_s;
  logic [sr_size-1:0] eidx_s;
  logic               is_branch_s;

  // Fetch uses the live history; training uses the history the branch was
  // predicted with, which execute carries back in exec_bhr.
  assign fidx_s      = fetch_pc[sr_size+1:2] ^ bhr_r;
  assign eidx_s      = exec_pc[sr_size+1:2] ^ exec_bhr;
  assign is_branch_s = (exec_opcode == op_br);

  assign pht_taken     = pht_r[fidx_s][1];
  assign bhr_out       = bhr_r;
  assign predict_taken = pht_taken & btb_hit;

  // Direction state: reset to weakly not-taken, trained only by conditional branches.
  always_ff @(posedge clk) begin
    if (rst) begin
      bhr_r <= {sr_size{1'b0}};
      for (int i = 0; i < pht_entries; i++) begin
        pht_r[i] <= ctr_init;
      end
    end else if (is_branch_s) begin
      pht_r[eidx_s] <= ctr_next(pht_r[eidx_s], exec_pcmux_sel);
      bhr_r         <= {bhr_r[sr_size-2:0], exec_pcmux_sel};
    end
  end

  btb_array #(
    .s_index (s_index)
  ) u_btb (
    .clk         (clk),
    .rst         (rst),
    .lookup_pc   (fetch_pc),
    .hit         (btb_hit),
    .target      (predict_target),
    .fill_en     (exec_pcmux_sel),
    .fill_pc     (exec_pc),
    .fill_target (exec_alu)
  );

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: directed scenarios followed by
// randomized traffic, all compared against an arithmetic reference model.
module tb_branch_predict_unit;

  localparam int SR    = 6;
  localparam int SI    = 9;
  localparam int PHT_N = 64;
  localparam int BTB_N = 512;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   fetch_pc;
  logic          predict_taken;
  logic [31:0]   predict_target;
  logic          btb_hit;
  logic          pht_taken;
  logic [SR-1:0] bhr_out;
  logic [6:0]    exec_opcode;
  logic [31:0]   exec_pc;
  logic          exec_pcmux_sel;
  logic [31:0]   exec_alu;
  logic [SR-1:0] exec_bhr;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  // Reference model state
  int          m_cnt   [PHT_N];
  int          m_bhr;
  bit          m_valid [BTB_N];
  int unsigned m_tag   [BTB_N];
  logic [31:0] m_tgt   [BTB_N];

  branch_predict_unit #(.sr_size(SR), .s_index(SI)) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_pc       (fetch_pc),
    .predict_taken  (predict_taken),
    .predict_target (predict_target),
    .btb_hit        (btb_hit),
    .pht_taken      (pht_taken),
    .bhr_out        (bhr_out),
    .exec_opcode    (exec_opcode),
    .exec_pc        (exec_pc),
    .exec_pcmux_sel (exec_pcmux_sel),
    .exec_alu       (exec_alu),
    .exec_bhr       (exec_bhr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected fetch-side outputs derived from the model for the current fetch_pc.
  task automatic check_fetch(input string tag);
    int          fidx;
    int          slot;
    bit          hit;
    bit          dir;
    logic [31:0] tgt;
    fidx = int'((fetch_pc >> 2) & 32'h3F) ^ m_bhr;
    dir  = (m_cnt[fidx] >= 2);
    slot = int'((fetch_pc >> 2) & 32'h1FF);
    hit  = m_valid[slot] && (m_tag[slot] == (fetch_pc >> 11));
    tgt  = hit ? m_tgt[slot] : 32'h0;
    chk({tag, ".pht_taken"},      {31'b0, pht_taken},     {31'b0, dir});
    chk({tag, ".btb_hit"},        {31'b0, btb_hit},       {31'b0, hit});
    chk({tag, ".predict_target"}, predict_target,         tgt);
    chk({tag, ".predict_taken"},  {31'b0, predict_taken}, {31'b0, dir & hit});
    chk({tag, ".bhr_out"},        {26'b0, bhr_out},       m_bhr);
  endtask

  // Apply the behavioural rules for one rising edge using the current inputs.
  task automatic model_edge();
    int e;
    int slot;
    if (rst) begin
      m_bhr = 0;
      foreach (m_cnt[i]) m_cnt[i] = 1;
      foreach (m_valid[i]) m_valid[i] = 1'b0;
    end else begin
      if (exec_opcode == 7'b1100011) begin
        e = int'((exec_pc >> 2) & 32'h3F) ^ int'(exec_bhr);
        if (exec_pcmux_sel) m_cnt[e] = (m_cnt[e] == 3) ? 3 : m_cnt[e] + 1;
        else                m_cnt[e] = (m_cnt[e] == 0) ? 0 : m_cnt[e] - 1;
        m_bhr = ((m_bhr << 1) | int'(exec_pcmux_sel)) & 63;
      end
      if (exec_pcmux_sel) begin
        slot          = int'((exec_pc >> 2) & 32'h1FF);
        m_valid[slot] = 1'b1;
        m_tag[slot]   = exec_pc >> 11;
        m_tgt[slot]   = exec_alu;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic [6:0] op, input logic [31:0] pc, input logic sel,
                       input logic [31:0] alu, input logic [SR-1:0] ebhr);
    exec_opcode    = op;
    exec_pc        = pc;
    exec_pcmux_sel = sel;
    exec_alu       = alu;
    exec_bhr       = ebhr;
  endtask

  task automatic idle();
    drive(7'h13, 32'h0, 1'b0, 32'h0, '0);
  endtask

  // Point fetch at the PC whose gshare index equals idx under the current history.
  task automatic probe_idx(input int idx, input string tag);
    fetch_pc = 32'(((idx ^ m_bhr) & 63) << 2);
    #1;
    check_fetch(tag);
  endtask

  initial begin
    logic [31:0] pool_pc;
    logic [6:0]  op;
    int          saved_bhr;

    // 1. reset
    rst = 1'b1;
    idle();
    fetch_pc = 32'h100;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check_fetch("reset");
    chk("reset_bhr", {26'b0, bhr_out}, 32'h0);
    chk("reset_hit", {31'b0, btb_hit}, 32'h0);

    // 2. two taken branches at 0x100
    drive(7'b1100011, 32'h100, 1'b1, 32'h200, 6'd0);
    tick();
    chk("train1_bhr", {26'b0, bhr_out}, 32'h01);
    tick();
    chk("train2_bhr", {26'b0, bhr_out}, 32'h03);
    idle();
    fetch_pc = 32'h100;
    #1;
    check_fetch("train_fetch");
    chk("train_hit", {31'b0, btb_hit}, 32'h1);
    chk("train_target", predict_target, 32'h200);
    probe_idx(0, "train_idx0");

    // 3. saturation: index 32 taken x4 then not-taken; index 40 not-taken x4
    for (int k = 0; k < 4; k++) begin
      drive(7'b1100011, 32'h180, 1'b1, 32'h280, 6'd0);
      tick();
      idle();
      probe_idx(32, "sat_up");
    end
    chk("sat_up_taken", {31'b0, pht_taken}, 32'h1);
    drive(7'b1100011, 32'h180, 1'b0, 32'h0, 6'd0);
    tick();
    idle();
    probe_idx(32, "sat_dn1");
    chk("sat_10_taken", {31'b0, pht_taken}, 32'h1);
    for (int k = 0; k < 4; k++) begin
      drive(7'b1100011, 32'h0A0, 1'b0, 32'h0, 6'd0);
      tick();
      idle();
      probe_idx(40, "sat_floor");
    end
    chk("sat_floor_taken", {31'b0, pht_taken}, 32'h0);

    // 4. BTB aliasing
    drive(7'b1101111, 32'h100 + (32'h1 << (SI + 2)), 1'b1, 32'h300, 6'd0);
    tick();
    idle();
    fetch_pc = 32'h100;
    #1;
    check_fetch("alias_orig");
    chk("alias_orig_hit", {31'b0, btb_hit}, 32'h0);
    fetch_pc = 32'h100 + (32'h1 << (SI + 2));
    #1;
    check_fetch("alias_new");
    chk("alias_new_target", predict_target, 32'h300);

    // 5. JAL fills BTB only; non-redirecting non-branch changes nothing
    saved_bhr = m_bhr;
    drive(7'b1101111, 32'h40, 1'b1, 32'h80, 6'd5);
    tick();
    idle();
    chk("jal_bhr", {26'b0, bhr_out}, saved_bhr);
    fetch_pc = 32'h40;
    #1;
    check_fetch("jal_fetch");
    chk("jal_target", predict_target, 32'h80);
    drive(7'h13, 32'h40, 1'b0, 32'h999, 6'd7);
    tick();
    idle();
    #1;
    check_fetch("nop_fetch");
    probe_idx(32, "nop_pht32");

    // 6. same-cycle fill and lookup, then reset during an update
    fetch_pc = 32'h100;
    drive(7'b1100111, 32'h100, 1'b1, 32'h123, 6'd0);
    #1;
    check_fetch("rw_same");
    chk("rw_same_hit", {31'b0, btb_hit}, 32'h0);
    tick();
    idle();
    #1;
    check_fetch("rw_next");
    chk("rw_next_hit", {31'b0, btb_hit}, 32'h1);
    rst = 1'b1;
    drive(7'b1100011, 32'h180, 1'b1, 32'h444, 6'd0);
    tick();
    rst = 1'b0;
    idle();
    #1;
    check_fetch("rst_mid");
    chk("rst_mid_hit", {31'b0, btb_hit}, 32'h0);
    chk("rst_mid_bhr", {26'b0, bhr_out}, 32'h0);
    probe_idx(32, "rst_mid_pht32");

    // 7. randomized traffic
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      case ($urandom_range(0, 3))
        0, 1:    op = 7'b1100011;
        2:       op = 7'b1101111;
        default: op = 7'b0110011;
      endcase
      pool_pc = (32'($urandom_range(0, 3)) << 11) | (32'($urandom_range(0, 15)) << 2);
      drive(op, pool_pc, 1'($urandom_range(0, 1)), $urandom,
            ($urandom_range(0, 1) == 1) ? 6'(m_bhr) : 6'($urandom_range(0, 63)));
      fetch_pc = (32'($urandom_range(0, 3)) << 11) | (32'($urandom_range(0, 15)) << 2);
      #1;
      check_fetch("rnd_pre");
      tick();
      check_fetch("rnd_post");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
